smem_batch_scheduler: RTL

Issues read numbers of a batch into the SMEM pipeline, limits how many reads are in flight, and retires reads as their mem-size results come back. Once every read in the batch has retired, it runs the request/permit/finish handshake with the host-output path that drains the curr/mem queue RAMs. It sits between the batch loader and the SMEM pipeline front end, and is the single source of `output_request` toward the host output arbiter.

---
 rtl/smem_batch_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/smem_batch_scheduler.sv
// SMEM batch scheduler: dispatches the reads of a batch into the SMEM pipeline under an
// in-flight credit limit, retires them as mem-size results return (in any order), then runs
// the request/permit/finish handshake with the host-output drain path.
module smem_batch_scheduler #(
    parameter int unsigned READ_NUM_WIDTH = 8,
    parameter int unsigned MAX_READ       = 256,
    parameter int unsigned MAX_INFLIGHT   = 32,
    parameter int unsigned CNT_W          = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic                      start,
    input  logic [READ_NUM_WIDTH:0]   batch_size,
    output logic                      dispatch_valid,
    input  logic                      dispatch_ready,
    output logic [READ_NUM_WIDTH-1:0] dispatch_read_num,
    input  logic                      done_valid,
    input  logic [READ_NUM_WIDTH-1:0] done_read_num,
    output logic                      output_request,
    input  logic                      output_permit,
    input  logic                      output_finish,
    output logic [CNT_W-1:0]          inflight,
    output logic                      busy,
    output logic                      batch_done,
    output logic                      error
);

    localparam int unsigned PW = READ_NUM_WIDTH + 1;
    localparam logic [PW-1:0]    MaxReadN     = PW'(MAX_READ);
    localparam logic [CNT_W-1:0] MaxInflightN = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {StIdle, StRun, StRequest, StDrain} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       next_ptr_q, next_ptr_d;
    logic [PW-1:0]       done_cnt_q, done_cnt_d;
    logic [PW-1:0]       bsize_q, bsize_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [MAX_READ-1:0] disp_map_q, disp_map_d;
    logic [MAX_READ-1:0] done_map_q, done_map_d;
    logic                error_q, error_d;
    logic                batch_done_q, batch_done_d;

    logic in_run;
    logic xfer;
    logic done_legal;
    logic start_ok;

    // Dispatch handshake and completion legality; stall masks the offer so nothing transfers.
    always_comb begin
        in_run         = (state_q == StRun);
        dispatch_valid = in_run && (next_ptr_q < bsize_q) && (inflight_q < MaxInflightN) &&
                         !stall;
        xfer           = dispatch_valid && dispatch_ready;
        // A completion only counts for a read that was dispatched and has not yet retired.
        done_legal     = done_valid && in_run && disp_map_q[done_read_num] &&
                         !done_map_q[done_read_num];
        start_ok       = (batch_size != '0) && (batch_size <= MaxReadN);
    end

    // Next-state logic for the FSM, counters and bitmaps.
    always_comb begin
        state_d      = state_q;
        next_ptr_d   = next_ptr_q;
        done_cnt_d   = done_cnt_q;
        bsize_d      = bsize_q;
        inflight_d   = inflight_q;
        disp_map_d   = disp_map_q;
        done_map_d   = done_map_q;
        error_d      = error_q;
        batch_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (start_ok) begin
                        bsize_d    = batch_size;
                        next_ptr_d = '0;
                        done_cnt_d = '0;
                        inflight_d = '0;
                        disp_map_d = '0;
                        done_map_d = '0;
                        state_d    = StRun;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (xfer) begin
                    next_ptr_d = next_ptr_q + PW'(1);
                    disp_map_d[next_ptr_q[READ_NUM_WIDTH-1:0]] = 1'b1;
                end
                if (done_legal) begin
                    done_map_d[done_read_num] = 1'b1;
                    done_cnt_d = done_cnt_q + PW'(1);
                end
                // Simultaneous transfer and retire cancel out on the credit count.
                if (xfer && !done_legal) begin
                    inflight_d = inflight_q + CNT_W'(1);
                end else if (!xfer && done_legal) begin
                    inflight_d = inflight_q - CNT_W'(1);
                end
                if (done_legal && (done_cnt_d == bsize_q)) begin
                    state_d = StRequest;
                end
            end
            StRequest: begin
                if (output_permit) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (output_finish) begin
                    state_d      = StIdle;
                    batch_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Any completion that did not retire a read is a protocol error, in every state.
        if (done_valid && !done_legal) begin
            error_d = 1'b1;
        end
    end

    // State register: synchronous active-low reset; stall freezes everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            next_ptr_q   <= '0;
            done_cnt_q   <= '0;
            bsize_q      <= '0;
            inflight_q   <= '0;
            disp_map_q   <= '0;
            done_map_q   <= '0;
            error_q      <= 1'b0;
            batch_done_q <= 1'b0;
        end else if (!stall) begin
            state_q      <= state_d;
            next_ptr_q   <= next_ptr_d;
            done_cnt_q   <= done_cnt_d;
            bsize_q      <= bsize_d;
            inflight_q   <= inflight_d;
            disp_map_q   <= disp_map_d;
            done_map_q   <= done_map_d;
            error_q      <= error_d;
            batch_done_q <= batch_done_d;
        end
    end

    // Registered status outputs; output_request decodes straight from the state register.
    always_comb begin
        dispatch_read_num = next_ptr_q[READ_NUM_WIDTH-1:0];
        output_request    = (state_q == StRequest) || (state_q == StDrain);
        busy              = (state_q != StIdle);
        inflight          = inflight_q;
        batch_done        = batch_done_q;
        error             = error_q;
    end

endmodule
